// File: rtl/usb_cdc_line_assembler.sv
// rtl/usb_cdc_line_assembler.sv - RX FIFO byte stream to CR/LF-terminated line buffer (optional echo: USB_CDC_LINE_ECHO_EN)
module usb_cdc_line_assembler #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4,
    parameter int LW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_fifo_empty,
    input  logic [7:0]    rx_fifo_rdata,
    output logic          rx_fifo_rd,
    output logic          line_valid,
    output logic [LW-1:0] line_len,
    input  logic          line_ack,
    input  logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt,
    input  logic          tx_fifo_full,
    output logic          tx_fifo_wr,
    output logic [7:0]    tx_fifo_wdata
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] len;
    logic [7:0]    line_buf [MAX_LEN];
    logic          is_term;
    logic          at_max;
    logic          echo_ok;

    assign is_term = (rx_fifo_rdata == 8'h0D) || (rx_fifo_rdata == 8'h0A);
    assign at_max  = (len == MAX_LEN_L);

`ifdef USB_CDC_LINE_ECHO_EN
    // Stall the RX side while the echo path cannot accept, so no echoed byte is lost.
    assign echo_ok       = ~tx_fifo_full;
    assign tx_fifo_wr    = rx_fifo_rd;
    assign tx_fifo_wdata = rx_fifo_rdata;
`else
    logic unused_tx_full;
    assign unused_tx_full = tx_fifo_full;
    assign echo_ok        = 1'b1;
    assign tx_fifo_wr     = 1'b0;
    assign tx_fifo_wdata  = 8'h00;
`endif

    // Bytes are consumed only while collecting or discarding; HOLD freezes the FIFO.
    assign rx_fifo_rd = ((state == COLLECT) || (state == DISCARD)) && !rx_fifo_empty && echo_ok;
    assign line_valid = (state == HOLD);
    assign buf_data   = line_buf[buf_addr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: terminators close a non-empty line, an overlong line flips to DISCARD.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (rx_fifo_rd) begin
                    if (is_term) begin
                        if (len != '0) begin
                            state_next = HOLD;
                        end
                    end else if (at_max) begin
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (rx_fifo_rd && is_term) begin
                    state_next = COLLECT;
                end
            end
            HOLD: begin
                if (line_ack) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Length, presented length, overflow pulse and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            len        <= '0;
            line_len   <= '0;
            overflow_o <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            overflow_o <= 1'b0;
            case (state)
                COLLECT: begin
                    if (rx_fifo_rd) begin
                        if (is_term) begin
                            if (len != '0) begin
                                line_len <= len;
                            end
                        end else if (!at_max) begin
                            len <= len + 1'b1;
                        end else begin
                            overflow_o <= 1'b1;
                            if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (rx_fifo_rd && is_term) begin
                        len <= '0;
                    end
                end
                HOLD: begin
                    if (line_ack) begin
                        len <= '0;
                    end
                end
                default: len <= '0;
            endcase
        end
    end

    // Line buffer write port; contents survive reset and are simply overwritten.
    always_ff @(posedge clk) begin
        if (!rst && (state == COLLECT) && rx_fifo_rd && !is_term && !at_max) begin
            line_buf[len[AW-1:0]] <= rx_fifo_rdata;
        end
    end

endmodule

// File: tb/tb_usb_cdc_line_assembler.sv
// tb/tb_usb_cdc_line_assembler.sv - self-checking bench for usb_cdc_line_assembler (honours USB_CDC_LINE_ECHO_EN)
module tb_usb_cdc_line_assembler;

    localparam int MAX_LEN = 16;
    localparam int AW      = 4;
    localparam int LW      = 5;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic          clk;
    logic          rst;
    logic          rx_fifo_empty;
    logic [7:0]    rx_fifo_rdata;
    logic          rx_fifo_rd;
    logic          line_valid;
    logic [LW-1:0] line_len;
    logic          line_ack;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          overflow_o;
    logic [7:0]    drop_cnt;
    logic          tx_fifo_full;
    logic          tx_fifo_wr;
    logic [7:0]    tx_fifo_wdata;

    usb_cdc_line_assembler #(.MAX_LEN(MAX_LEN), .AW(AW), .LW(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rdata (rx_fifo_rdata),
        .rx_fifo_rd    (rx_fifo_rd),
        .line_valid    (line_valid),
        .line_len      (line_len),
        .line_ack      (line_ack),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .overflow_o    (overflow_o),
        .drop_cnt      (drop_cnt),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_wr    (tx_fifo_wr),
        .tx_fifo_wdata (tx_fifo_wdata)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int lines_seen = 0;
    int ovf_seen = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] echo_q [$];

    // Reference model: line-level view of the byte stream.
    logic [7:0] m_cur [$];
    bit         m_disc = 1'b0;
    int         m_ovf = 0;
    int         m_drop = 0;
    int         exp_len [$];
    logic [7:0] exp_data [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (b == CR || b == LF) begin
            if (m_disc) begin
                m_disc = 1'b0;
            end else if (m_cur.size() > 0) begin
                exp_len.push_back(m_cur.size());
                foreach (m_cur[i]) exp_data.push_back(m_cur[i]);
            end
            m_cur.delete();
        end else if (!m_disc) begin
            if (m_cur.size() == MAX_LEN) begin
                m_disc = 1'b1;
                m_ovf++;
                if (m_drop < 255) m_drop++;
                m_cur.delete();
            end else begin
                m_cur.push_back(b);
            end
        end
    endtask

    task automatic model_reset();
        m_cur.delete();
        m_disc = 1'b0;
        m_drop = 0;
    endtask

    task automatic drive_fifo();
        rx_fifo_empty = (fifo_q.size() == 0);
        rx_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        model_push(b);
        drive_fifo();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    // One clock: sample at the falling edge, then pop the FIFO model after the rising edge.
    task automatic tick();
        logic rd_s;
        @(negedge clk);
        rd_s = rx_fifo_rd;
        if (overflow_o) ovf_seen++;
        chk("hold_no_pop", 32'(line_valid & rx_fifo_rd), 32'd0);
        chk("no_pop_when_empty", 32'(rx_fifo_empty & rx_fifo_rd), 32'd0);
`ifdef USB_CDC_LINE_ECHO_EN
        chk("echo_wr", 32'(tx_fifo_wr), 32'(rx_fifo_rd));
        if (tx_fifo_wr) begin
            chk("echo_data", 32'(tx_fifo_wdata), 32'(rx_fifo_rdata));
            echo_q.push_back(tx_fifo_wdata);
        end
`else
        chk("no_echo", {23'd0, tx_fifo_wr, tx_fifo_wdata}, 32'd0);
`endif
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic check_line();
        int n;
        lines_seen++;
        if (exp_len.size() == 0) begin
            chk("unexpected_line", 32'(line_valid), 32'd0);
            return;
        end
        n = exp_len.pop_front();
        chk("line_len", 32'(line_len), 32'(n));
        for (int i = 0; i < n; i++) begin
            buf_addr = i[AW-1:0];
            #1;
            chk("buf_data", 32'(buf_data), 32'(exp_data.pop_front()));
        end
    endtask

    task automatic do_ack();
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        chk("ack_clears_valid", 32'(line_valid), 32'd0);
    endtask

    task automatic drain(input int bound);
        int i;
        i = 0;
        while ((fifo_q.size() != 0 || line_valid) && i < bound) begin
            if (line_valid) begin
                check_line();
                repeat ($urandom_range(0, 2)) tick();
                do_ack();
            end else begin
                tick();
            end
            i++;
        end
        chk("drain_done", 32'(fifo_q.size() != 0 || line_valid), 32'd0);
        chk("lines_all_seen", 32'(exp_len.size()), 32'd0);
    endtask

    task automatic wait_valid(input int bound);
        int i;
        i = 0;
        while (!line_valid && i < bound) begin
            tick();
            i++;
        end
        chk("wait_valid", 32'(line_valid), 32'd1);
    endtask

    initial begin
        int l0;
        int o0;
        int n;
        rst = 1'b1;
        line_ack = 1'b0;
        buf_addr = '0;
        tx_fifo_full = 1'b0;
        drive_fifo();

        // Reset state
        tick();
        tick();
        chk("rst_line_valid", 32'(line_valid), 32'd0);
        chk("rst_line_len", 32'(line_len), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_rd", 32'(rx_fifo_rd), 32'd0);
        chk("rst_tx", {23'd0, tx_fifo_wr, tx_fifo_wdata}, 32'd0);
        rst = 1'b0;
        tick();

        // "AB\r": one-cycle latency after the CR pop
        push_str("AB");
        push_byte(CR);
        tick();
        tick();
        chk("ab_not_yet_valid", 32'(line_valid), 32'd0);
        tick();
        chk("ab_valid_latency", 32'(line_valid), 32'd1);
        chk("ab_len", 32'(line_len), 32'd2);
        buf_addr = 4'd0;
        #1;
        chk("ab_buf0", 32'(buf_data), 32'h41);
        buf_addr = 4'd1;
        #1;
        chk("ab_buf1", 32'(buf_data), 32'h42);
        check_line();
        do_ack();

        // Blank lines and CRLF pairs produce no line
        l0 = lines_seen;
        push_byte(CR); push_byte(LF); push_byte(CR); push_byte(LF);
        push_str("X"); push_byte(LF);
        drain(200);
        chk("crlf_one_line", 32'(lines_seen - l0), 32'd1);

        // Exactly MAX_LEN is a line; MAX_LEN+1 overflows once
        for (int i = 0; i < MAX_LEN; i++) push_byte(8'h55);
        push_byte(LF);
        drain(200);
        l0 = lines_seen;
        o0 = ovf_seen;
        for (int i = 0; i < MAX_LEN + 1; i++) push_byte(8'h55);
        push_byte(LF);
        drain(200);
        chk("ovf_pulse_once", 32'(ovf_seen - o0), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("ovf_no_line", 32'(lines_seen - l0), 32'd0);
        push_str("Z"); push_byte(LF);
        drain(200);
        chk("after_ovf_line", 32'(lines_seen - l0), 32'd1);

        // HOLD blocks popping; after ack bytes drain on consecutive cycles
        push_str("Q"); push_byte(LF);
        wait_valid(20);
        push_str("wxyz");
        repeat (5) begin
            tick();
            chk("hold_rd_low", 32'(rx_fifo_rd), 32'd0);
            chk("hold_fifo_kept", 32'(fifo_q.size()), 32'd4);
        end
        check_line();
        do_ack();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("resume_pop", 32'(fifo_q.size()), 32'(4 - k));
        end
        push_byte(LF);
        drain(200);

        // Randomized lines with mid-line FIFO stalls
        for (int ln = 0; ln < 40; ln++) begin
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                push_byte(8'($urandom_range(32, 126)));
                if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
            end
            push_byte($urandom_range(0, 1) ? CR : LF);
            drain(400);
        end
        chk("rand_drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("rand_ovf_pulses", 32'(ovf_seen), 32'(m_ovf));

        // Drop counter saturation
        for (int r = 0; r < 256; r++) begin
            for (int i = 0; i < MAX_LEN + 1; i++) push_byte(8'h61);
            push_byte(LF);
        end
        drain(12000);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_ovf_pulses", 32'(ovf_seen), 32'(m_ovf));

        // Reset mid-line discards the partial line and counters
        push_str("abc");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("midrst_line_valid", 32'(line_valid), 32'd0);
        chk("midrst_line_len", 32'(line_len), 32'd0);
        l0 = lines_seen;
        push_str("Z"); push_byte(LF);
        drain(200);
        chk("midrst_len_cleared", 32'(lines_seen - l0), 32'd1);

        // Echo path and TX-full back-pressure
        echo_q.delete();
        tx_fifo_full = 1'b1;
        l0 = lines_seen;
        push_str("Hi"); push_byte(LF);
`ifdef USB_CDC_LINE_ECHO_EN
        repeat (3) begin
            tick();
            chk("txfull_rd_low", 32'(rx_fifo_rd), 32'd0);
            chk("txfull_fifo_kept", 32'(fifo_q.size()), 32'd3);
        end
        tx_fifo_full = 1'b0;
        drain(200);
        chk("echo_count", 32'(echo_q.size()), 32'd3);
        if (echo_q.size() == 3) begin
            chk("echo_b0", 32'(echo_q[0]), 32'h48);
            chk("echo_b1", 32'(echo_q[1]), 32'h69);
            chk("echo_b2", 32'(echo_q[2]), 32'h0A);
        end
`else
        drain(200);
        tx_fifo_full = 1'b0;
        chk("txfull_ignored_count", 32'(echo_q.size()), 32'd0);
`endif
        chk("echo_line_seen", 32'(lines_seen - l0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
